// File: rtl/skew_pkg.sv
// skew_pkg: FSM state encoding and beat/run-length derivation shared by the skew load and collect blocks
package skew_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} skew_state_t;

    function automatic int beats(input int s, input int n);
        return s / n;
    endfunction

    function automatic int run_len(input int s, input int n, input int r);
        return s / n + r - 1;
    endfunction

endpackage

// File: rtl/skew_enable_gen.sv
// skew_enable_gen: enable window for one row, high while row <= t < row + BEATS
module skew_enable_gen #(
    parameter int TW    = 3,
    parameter int IW    = 3,
    parameter int BEATS = 4
) (
    input  logic [TW-1:0] i_t,
    input  logic [IW-1:0] i_row,
    output logic          o_en
);

    assign o_en = (int'(i_t) >= int'(i_row)) && (int'(i_t) < int'(i_row) + BEATS);

endmodule

// File: rtl/skew_load_ctrl.sv
// skew_load_ctrl: loads R row words, then enables each downstream ring shifter for BEATS cycles, skewed one cycle per row
module skew_load_ctrl
    import skew_pkg::*;
#(
    parameter int S = 8,
    parameter int N = 2,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [S-1:0]   row_in,
    output logic [R*S-1:0] row_word,
    output logic [R-1:0]   row_enable,
    output logic           busy,
    output logic           done
);

    localparam int BEATS   = beats(S, N);
    localparam int RUN_LEN = run_len(S, N, R);
    localparam int IW      = $clog2(R + 1);
    localparam int TW      = $clog2(RUN_LEN + 1);

    skew_state_t    r_state, w_next;
    logic [IW-1:0]  r_row_idx;
    logic [TW-1:0]  r_t, w_t_next;
    logic [R*S-1:0] r_row_word;
    logic [R-1:0]   r_en, w_gen, w_en_next;
    logic           w_accept;

    // enable windows are evaluated for the t value of the coming cycle so row_enable can be registered
    for (genvar i = 0; i < R; i++) begin : g_en
        skew_enable_gen #(.TW(TW), .IW(IW), .BEATS(BEATS)) u_en (
            .i_t  (w_t_next),
            .i_row(IW'(i)),
            .o_en (w_gen[i])
        );
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // next-state logic and derived next values of t and the enables
    always_comb begin
        w_next   = r_state;
        w_accept = (r_state == ST_LOAD) && in_valid;
        case (r_state)
            ST_IDLE: w_next = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: w_next = (w_accept && r_row_idx == IW'(R - 1)) ? ST_RUN : ST_LOAD;
            ST_RUN:  w_next = (r_t == TW'(RUN_LEN - 1)) ? ST_DONE : ST_RUN;
            default: w_next = ST_IDLE;
        endcase
        w_t_next  = (r_state == ST_RUN) ? r_t + 1'b1 : '0;
        w_en_next = (w_next == ST_RUN) ? w_gen : '0;
    end

    // row capture, counters and registered enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_idx  <= '0;
            r_t        <= '0;
            r_row_word <= '0;
            r_en       <= '0;
        end else begin
            r_t  <= w_t_next;
            r_en <= w_en_next;
            if (r_state == ST_IDLE && start) r_row_idx <= '0;
            if (w_accept) begin
                r_row_word[int'(r_row_idx) * S +: S] <= row_in;
                r_row_idx <= r_row_idx + 1'b1;
            end
        end
    end

    assign in_ready   = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign row_word   = r_row_word;
    assign row_enable = r_en;

endmodule

// File: tb/tb_skew_load_ctrl.sv
// tb_skew_load_ctrl: scenario tasks checking skew_load_ctrl against a window/emission reference model
module tb_skew_load_ctrl;

    localparam int S       = 8;
    localparam int N       = 2;
    localparam int R       = 4;
    localparam int BEATS   = S / N;
    localparam int RUN_LEN = BEATS + R - 1;

    logic           clk = 1'b0;
    logic           rst, start, in_valid, in_ready, busy, done;
    logic [S-1:0]   row_in;
    logic [R*S-1:0] row_word;
    logic [R-1:0]   row_enable;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [S-1:0]   rows [R];
    int             stall [R];
    logic [R*S-1:0] exp_word;

    skew_load_ctrl #(.S(S), .N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_in    (row_in),
        .row_word  (row_word),
        .row_enable(row_enable),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // row i is enabled on RUN cycle k exactly when i <= k < i + BEATS
    function automatic logic [R-1:0] exp_en(input int k);
        logic [R-1:0] e;
        for (int i = 0; i < R; i++) e[i] = (k >= i) && (k < i + BEATS);
        return e;
    endfunction

    // run one load/run sequence from IDLE; abort_at >= 0 asserts rst at that RUN cycle and returns
    task automatic do_seq(input int abort_at, input bit poke_start);
        int           cnt [R];
        logic [R*S-1:0] sh;
        int           got, want;
        for (int i = 0; i < R; i++) cnt[i] = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_entry: in_ready=%b busy=%b, need 1 1", in_ready, busy);
        end
        for (int r = 0; r < R; r++) begin
            for (int s = 0; s < stall[r]; s++) begin
                in_valid = 1'b0;
                row_in   = S'($urandom);
                step();
                n_checks++;
                if (in_ready !== 1'b1 || row_enable !== '0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_stall: in_ready=%b en=%b busy=%b, need 1 0000 1", in_ready, row_enable, busy);
                end
            end
            in_valid = 1'b1;
            row_in   = rows[r];
            step();
            exp_word[r*S +: S] = rows[r];
            in_valid = 1'b0;
            row_in   = S'($urandom);
            if (r < R - 1) begin
                n_checks++;
                if (in_ready !== 1'b1 || row_word !== exp_word) begin
                    n_fail++;
                    $display("FAIL load_accept row %0d: in_ready=%b word=%h, need 1 %h", r, in_ready, row_word, exp_word);
                end
            end
        end
        for (int k = 0; k < RUN_LEN; k++) begin
            n_checks++;
            if (row_enable !== exp_en(k) || done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL run k=%0d: en=%b done=%b busy=%b rdy=%b, need %b 0 1 0", k, row_enable, done, busy, in_ready, exp_en(k));
            end
            n_checks++;
            if (row_word !== exp_word) begin
                n_fail++;
                $display("FAIL run_word k=%0d: got %h need %h", k, row_word, exp_word);
            end
            for (int i = 0; i < R; i++) begin
                if (row_enable[i] === 1'b1 && cnt[i] < BEATS) begin
                    sh   = row_word >> (i * S + cnt[i] * N);
                    got  = int'(sh[N-1:0]);
                    want = (int'(rows[i]) >> (cnt[i] * N)) & ((1 << N) - 1);
                    n_checks++;
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL emit row %0d beat %0d: got %0d need %0d", i, cnt[i], got, want);
                    end
                end
                if (row_enable[i] === 1'b1) cnt[i]++;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                return;
            end
            start    = poke_start && (k == 2);
            in_valid = 1'($urandom);
            row_in   = S'($urandom);
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || row_enable !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b en=%b busy=%b rdy=%b, need 1 0000 0 0", done, row_enable, busy, in_ready);
        end
        for (int i = 0; i < R; i++) begin
            n_checks++;
            if (cnt[i] !== BEATS) begin
                n_fail++;
                $display("FAIL beat_count row %0d: got %0d need %0d", i, cnt[i], BEATS);
            end
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || row_word !== exp_word || row_enable !== '0) begin
            n_fail++;
            $display("FAIL back_idle: done=%b busy=%b word=%h en=%b, need 0 0 %h 0000", done, busy, row_word, row_enable, exp_word);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_word = '0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || row_enable !== '0 || row_word !== '0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b busy=%b done=%b en=%b word=%h, need all 0", in_ready, busy, done, row_enable, row_word);
        end
    endtask

    task automatic test_basic();
        rows[0] = 8'h1B; rows[1] = 8'h2C; rows[2] = 8'h3D; rows[3] = 8'h4E;
        for (int i = 0; i < R; i++) stall[i] = 0;
        do_seq(-1, 1'b0);
    endtask

    task automatic test_stall();
        rows[0] = 8'h1B; rows[1] = 8'h2C; rows[2] = 8'h3D; rows[3] = 8'h4E;
        for (int i = 0; i < R; i++) stall[i] = 0;
        stall[2] = 3;
        do_seq(-1, 1'b0);
        n_checks++;
        if (row_word !== 32'h4E3D2C1B) begin
            n_fail++;
            $display("FAIL stall_word: got %h need 4e3d2c1b", row_word);
        end
    endtask

    task automatic test_start_during_run();
        for (int i = 0; i < R; i++) begin
            rows[i]  = S'($urandom);
            stall[i] = 0;
        end
        do_seq(-1, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%b rdy=%b, need 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < R; i++) begin
            rows[i]  = S'($urandom);
            stall[i] = int'($urandom_range(0, 2));
        end
        do_seq(3, 1'b0);
        step();
        rst = 1'b0;
        exp_word = '0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (row_enable !== '0 || row_word !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort c=%0d: en=%b word=%h busy=%b done=%b rdy=%b, need all 0", c, row_enable, row_word, busy, done, in_ready);
            end
            step();
        end
        for (int i = 0; i < R; i++) rows[i] = S'($urandom);
        do_seq(-1, 1'b0);
    endtask

    task automatic test_idle_ignore();
        in_valid = 1'b1;
        row_in   = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (in_ready !== 1'b0 || row_word !== exp_word || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignore c=%0d: rdy=%b word=%h busy=%b, need 0 %h 0", c, in_ready, row_word, busy, exp_word);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < R; i++) begin
                rows[i]  = S'($urandom);
                stall[i] = int'($urandom_range(0, 3));
            end
            do_seq(-1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; row_in = '0; exp_word = '0;
        test_reset();
        test_basic();
        test_stall();
        test_start_during_run();
        test_reset_mid_run();
        test_idle_ignore();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skew_load_ctrl.md
SKEW_LOAD_CTRL -- requirements
Module: skew_load_ctrl

Interface
REQ-001 SHALL have parameter S, default 8: bit width of one matrix row word.
REQ-002 SHALL have parameter N, default 2: bits emitted per beat by each downstream RingShiftRegister; S SHALL be a multiple of N.
REQ-003 SHALL have parameter R, default 4: number of rows, equal to the number of downstream RingShiftRegister instances.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  the single clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load/run sequence.
REQ-008 in_valid  input  1  row_in holds a valid row word.
REQ-009 in_ready  output  1  block accepts a row word this cycle.
REQ-010 row_in  input  S  row word; rows arrive in order 0..R-1.
REQ-011 row_word  output  R*S  slice i, bits [i*S +: S], drives the `in` port of RingShiftRegister i.
REQ-012 row_enable  output  R  bit i drives the `enable` port of RingShiftRegister i.
REQ-013 busy  output  1  high in LOAD and RUN.
REQ-014 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-015 SHALL define BEATS = S/N and RUN_LEN = BEATS + R - 1.
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-017 IDLE: in_ready=0, row_enable=0; start=1 SHALL move to LOAD and clear the row index.
REQ-018 LOAD: in_ready=1; on in_valid&&in_ready, row_in SHALL be written to slice row_idx of row_word and row_idx SHALL increment; after accepting row R-1, SHALL move to RUN with cycle counter t=0.
REQ-019 RUN: in_ready=0; row_enable[i] SHALL be registered high exactly when i <= t < i+BEATS, so row i is enabled for exactly BEATS consecutive cycles, skewed one cycle per row.
REQ-020 RUN: t SHALL increment every cycle; when t = RUN_LEN-1, the next state SHALL be DONE.
REQ-021 DONE: done=1 and row_enable=0 for exactly one cycle, then the next state SHALL be IDLE.
REQ-022 row_word SHALL be held stable from its write until the next LOAD overwrites it, because the downstream block samples `in` whenever `enable` is 0.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 in_valid SHALL be ignored outside LOAD.
REQ-025 row_in SHALL be consumed only when in_valid is asserted.
REQ-026 Stalls (in_valid=0) in LOAD SHALL hold state indefinitely.
REQ-027 The first enabled cycle of row i SHALL be the cycle in which RingShiftRegister i emits bits [N-1:0] of its row word; no enable cycle SHALL be wasted or extra.
REQ-028 Counters SHALL be sized clog2(R+1) for row_idx and clog2(RUN_LEN+1) for t; there SHALL be no wrap-around within a sequence.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, row_enable=0, in_ready=0, busy=0, done=0, row_word=0, row_idx=0, t=0.
REQ-030 rst SHALL take priority over every other input in every state.
REQ-031 Reset mid-LOAD or mid-RUN SHALL abort the sequence with no done pulse.

Structure
REQ-032 The state encoding and the BEATS/RUN_LEN derivation SHALL reside in shared package skew_pkg, for reuse by the output-side collector.
REQ-033 The enable-window comparator SHALL be one sub-module, skew_enable_gen (inputs t and row index; output one enable bit), instantiated R times.
REQ-034 The block SHALL NOT instantiate RingShiftRegister; the connection is made in the parent.

Verification (S=8, N=2, R=4)
REQ-035 Rows 0x1B, 0x2C, 0x3D, 0x4E loaded back-to-back, then RUN -> row_enable sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, then done pulse; downstream ring 0 emits 3, 2, 1, 0.
REQ-036 in_valid low for 3 cycles between rows 1 and 2 -> LOAD holds, row_idx stays 2, no enable asserted, final row_word = 0x4E3D2C1B.
REQ-037 start pulsed during RUN -> ignored; exactly one done pulse, at t=7 after RUN entry.
REQ-038 rst asserted at RUN t=3 -> next cycle row_enable=0, row_word=0, state IDLE, no done pulse; a new start then works normally.
REQ-039 in_valid=1 with row_in=0xFF held in IDLE for 5 cycles -> in_ready=0 and row_word unchanged.
REQ-040 Two sequences separated by one idle cycle -> second sequence's row_word fully replaces the first's and its enable pattern is identical.
